// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: compare opcodes, predictor
// counter encodings and the saturating-counter step function.
package branch_pkg;

    // Compare opcodes carried on d_op_i; encodings 7..15 resolve not-taken.
    typedef enum logic [3:0] {
        CMP_BEQ    = 4'd0,
        CMP_BNE    = 4'd1,
        CMP_BGEZ   = 4'd2,
        CMP_BGTZ   = 4'd3,
        CMP_BLEZ   = 4'd4,
        CMP_BLTZ   = 4'd5,
        CMP_BONALL = 4'd6
    } cmp_op_e;

    // 2-bit saturating predictor counter; MSB is the predicted direction.
    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } bp_state_e;

    // One step toward ST on taken, toward SN on not-taken, saturating at both ends.
    function automatic bp_state_e bp_next(input bp_state_e cur, input logic taken);
        bp_state_e nxt;
        nxt = cur;
        case (cur)
            SN:      nxt = taken ? WN : SN;
            WN:      nxt = taken ? WT : SN;
            WT:      nxt = taken ? ST : WN;
            ST:      nxt = taken ? ST : WT;
            default: nxt = WN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Purely combinational branch-condition evaluator, WIDTH-parametrised.
// Operand A is two's-complement signed for the zero-relative compares.
module branch_cmp_core
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic             taken_o
);

    logic [WIDTH-1:0] sum;
    logic             a_neg;
    logic             a_zero;

    // Evaluate the selected condition; unused opcodes resolve not-taken.
    always_comb begin
        sum     = a_i + b_i;
        a_neg   = a_i[WIDTH-1];
        a_zero  = (a_i == '0);
        taken_o = 1'b0;
        case (op_i)
            CMP_BEQ:    taken_o = (a_i == b_i);
            CMP_BNE:    taken_o = (a_i != b_i);
            CMP_BGEZ:   taken_o = ~a_neg;
            CMP_BGTZ:   taken_o = ~a_neg & ~a_zero;
            CMP_BLEZ:   taken_o = a_neg | a_zero;
            CMP_BLTZ:   taken_o = a_neg;
            CMP_BONALL: taken_o = (sum == '0);
            default:    taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution plus a 2-bit bimodal direction predictor.
// Optional statistics counters are enabled by defining BRANCH_UNIT_STATS_EN;
// without it the stat outputs are tied to zero and no counter flops exist.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      f_pc_i,
    output logic             f_pred_o,
    input  logic             d_valid_i,
    input  logic             d_stall_i,
    input  logic [31:0]      d_pc_i,
    input  logic             d_pred_i,
    input  logic [WIDTH-1:0] d_a_i,
    input  logic [WIDTH-1:0] d_b_i,
    input  logic [3:0]       d_op_i,
    output logic             d_taken_o,
    output logic             d_mispred_o,
    output logic [31:0]      stat_taken_o,
    output logic [31:0]      stat_mispred_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic             cmp_taken;
    logic             upd_en;
    logic [1:0]       f_entry;
    bp_state_e        table_q [DEPTH];
    bp_state_e        table_d [DEPTH];
    logic             unused_pc;

    assign f_idx     = f_pc_i[IDX_W+1:2];
    assign d_idx     = d_pc_i[IDX_W+1:2];
    assign unused_pc = ^{f_pc_i[31:IDX_W+2], f_pc_i[1:0], d_pc_i[31:IDX_W+2], d_pc_i[1:0]};

    branch_cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a_i     (d_a_i),
        .b_i     (d_b_i),
        .op_i    (d_op_i),
        .taken_o (cmp_taken)
    );

    // Resolve outcome and misprediction, both forced low when no branch is present.
    always_comb begin
        d_taken_o   = d_valid_i & cmp_taken;
        d_mispred_o = d_valid_i & (cmp_taken ^ d_pred_i);
        upd_en      = d_valid_i & ~d_stall_i;
    end

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        f_entry  = table_q[f_idx];
        f_pred_o = f_entry[1];
    end

    // Next table state: only the resolving entry moves, once per non-stalled branch.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (upd_en) begin
            table_d[d_idx] = bp_next(table_q[d_idx], cmp_taken);
        end
    end

    // Table register; reset reloads every entry to weakly-not-taken and wins over updates.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reset) begin
                table_q[i] <= WN;
            end else begin
                table_q[i] <= table_d[i];
            end
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_taken_q;
    logic [31:0] stat_taken_d;
    logic [31:0] stat_mispred_q;
    logic [31:0] stat_mispred_d;

    // Count resolved branches at their single update point; counters wrap naturally.
    always_comb begin
        stat_taken_d   = stat_taken_q;
        stat_mispred_d = stat_mispred_q;
        if (upd_en && d_taken_o) begin
            stat_taken_d = stat_taken_q + 32'd1;
        end
        if (upd_en && d_mispred_o) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_taken_q   <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_taken_q   <= stat_taken_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_taken_o   = stat_taken_q;
    assign stat_mispred_o = stat_mispred_q;
`else
    assign stat_taken_o   = '0;
    assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios followed by
// randomized traffic compared against a behavioural predictor model.
module tb_branch_unit;

`ifdef BRANCH_UNIT_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        f_pred;
    logic        d_valid;
    logic        d_stall;
    logic [31:0] d_pc;
    logic        d_pred;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [3:0]  d_op;
    logic        d_taken;
    logic        d_mispred;
    logic [31:0] stat_taken;
    logic [31:0] stat_mispred;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: counter value 0..3 per entry, predicted taken when >= 2.
    int          mtab [DEPTH];
    int unsigned m_taken;
    int unsigned m_mis;

    always #5 clk = ~clk;

    branch_unit #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .f_pc_i         (f_pc),
        .f_pred_o       (f_pred),
        .d_valid_i      (d_valid),
        .d_stall_i      (d_stall),
        .d_pc_i         (d_pc),
        .d_pred_i       (d_pred),
        .d_a_i          (d_a),
        .d_b_i          (d_b),
        .d_op_i         (d_op),
        .d_taken_o      (d_taken),
        .d_mispred_o    (d_mispred),
        .stat_taken_o   (stat_taken),
        .stat_mispred_o (stat_mispred)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        logic [31:0] s;
        sa = $signed(a);
        s  = a + b;
        case (op)
            4'd0:    return a == b;
            4'd1:    return a != b;
            4'd2:    return sa >= 0;
            4'd3:    return sa > 0;
            4'd4:    return sa <= 0;
            4'd5:    return sa < 0;
            4'd6:    return s == 32'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_stat(input int unsigned v);
        return STATS_EN ? v : 32'd0;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] pc, input logic p,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        d_valid = v;
        d_stall = s;
        d_pc    = pc;
        d_pred  = p;
        d_a     = a;
        d_b     = b;
        d_op    = op;
    endtask

    // Check combinational outputs against the model, clock once, advance the model.
    task automatic tick();
        logic t;
        logic m;
        #1;
        t = d_valid && ref_taken(d_op, d_a, d_b);
        m = d_valid && (ref_taken(d_op, d_a, d_b) != d_pred);
        check("d_taken", {31'd0, d_taken}, {31'd0, t});
        check("d_mispred", {31'd0, d_mispred}, {31'd0, m});
        check("f_pred", {31'd0, f_pred}, (mtab[idx(f_pc)] >= 2) ? 32'd1 : 32'd0);
        check("stat_taken", stat_taken, exp_stat(m_taken));
        check("stat_mispred", stat_mispred, exp_stat(m_mis));
        @(posedge clk);
        if (reset) begin
            foreach (mtab[i]) mtab[i] = 1;
            m_taken = 0;
            m_mis   = 0;
        end else if (d_valid && !d_stall) begin
            if (t) mtab[idx(d_pc)] = (mtab[idx(d_pc)] < 3) ? mtab[idx(d_pc)] + 1 : 3;
            else   mtab[idx(d_pc)] = (mtab[idx(d_pc)] > 0) ? mtab[idx(d_pc)] - 1 : 0;
            if (t) m_taken++;
            if (m) m_mis++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        foreach (mtab[i]) mtab[i] = 0;
        m_taken = 0;
        m_mis   = 0;
        reset   = 1'b1;
        f_pc    = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd0);
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // Reset state
        #1;
        check("rst_fpred", {31'd0, f_pred}, 32'd0);
        check("rst_stat_t", stat_taken, 32'd0);
        check("rst_stat_m", stat_mispred, 32'd0);

        // Signed compare corner and bonall / unused opcode
        drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h8000_0000, 32'h0, 4'd2);
        #1 check("bgez_neg", {31'd0, d_taken}, 32'd0);
        d_a = 32'h0;
        #1 check("bgez_zero", {31'd0, d_taken}, 32'd1);
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h5, 32'hFFFF_FFFB, 4'd6);
        #1 check("bonall", {31'd0, d_taken}, 32'd1);
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h5, 32'h5, 4'd9);
        #1 check("op9", {31'd0, d_taken}, 32'd0);
        check("op9_mis", {31'd0, d_mispred}, 32'd1);
        d_valid = 1'b0;
        d_op    = 4'd0;
        #1 check("novalid", {31'd0, d_taken | d_mispred}, 32'd0);
        tick();

        // Training sequence on 0x3000: three taken, then three not-taken
        do_reset();
        f_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h3000, 1'b1, 32'h7, 32'h7, 4'd0);
            #1 check("train_t", {31'd0, f_pred}, (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        #1 check("train_t3", {31'd0, f_pred}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h3000, 1'b1, 32'h7, 32'h8, 4'd0);
            tick();
            #1 check("train_nt", {31'd0, f_pred}, (i == 0) ? 32'd1 : 32'd0);
        end

        // Stalled branch at 0x3004 updates exactly once
        do_reset();
        f_pc = 32'h3004;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i < 4), 32'h3004, 1'b0, 32'h1, 32'h1, 4'd0);
            tick();
        end
        d_valid = 1'b0;
        #1 check("stall_wt", {31'd0, f_pred}, 32'd1);
        check("stall_stat", stat_taken, STATS_EN ? 32'd1 : 32'd0);
        drive(1'b1, 1'b0, 32'h3004, 1'b1, 32'h1, 32'h2, 4'd0);
        tick();
        #1 check("stall_once", {31'd0, f_pred}, 32'd0);

        // Same-cycle lookup and update on 0x3008
        do_reset();
        f_pc = 32'h3008;
        drive(1'b1, 1'b0, 32'h3008, 1'b0, 32'h0, 32'h0, 4'd0);
        #1 check("bypass_old", {31'd0, f_pred}, 32'd0);
        check("bypass_mis", {31'd0, d_mispred}, 32'd1);
        tick();
        d_valid = 1'b0;
        #1 check("bypass_new", {31'd0, f_pred}, 32'd1);
        check("bypass_stat", stat_mispred, STATS_EN ? 32'd1 : 32'd0);

        // Reset wins over a concurrent update after training to ST
        f_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h3000, 1'b0, 32'h4, 32'h4, 4'd0);
            tick();
        end
        #1 check("pre_rst_st", {31'd0, f_pred}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_valid = 1'b0;
        #1 check("rst_win_pred", {31'd0, f_pred}, 32'd0);
        check("rst_win_st", stat_taken, 32'd0);
        check("rst_win_sm", stat_mispred, 32'd0);
        f_pc = 32'h3008;
        #1 check("rst_all_wn", {31'd0, f_pred}, 32'd0);

        // Randomized traffic with a small PC pool to force index collisions
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = a;
                1:       b = -a;
                2:       b = 32'h0;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = {30'd0, 2'($urandom_range(0, 3))} - 32'd1;
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  {$urandom_range(0, 3) == 0 ? 24'h00_00AB : 24'h0, 8'h0} | (32'($urandom_range(0, 15)) << 2),
                  1'($urandom), a, b, 4'($urandom_range(0, 15)));
            f_pc = ($urandom_range(0, 1) == 0) ? d_pc : (32'($urandom_range(0, 15)) << 2) ^ 32'h1000;
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
